cube_arbiter: RTL and testbench
===============================

Name: cube_arbiter

Overview:
- Shares one cube-root unit (cube: start/busy handshake, 8-bit x in, 8-bit y out) between N_REQ requesters.
- Round-robin grant; drives the unit's start and operand, waits for the busy cycle, returns the result to the granted requester with a one-cycle done pulse.
- Watchdog flags a hung unit.
- Sits between the requesting datapath blocks and the single cube instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
W, 8, operand/result width
BUSY_WAIT, 4, max cycles start is held waiting for busy_i to rise
TIMEOUT, 1023, max cycles busy_i may stay high before abort

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous, active-low reset
req_i  input  N_REQ  request per requester, held until ack
x_bi  input  N_REQ*W  operands, requester k at bits [k*W +: W], stable while req_i[k]=1
ack_o  output  N_REQ  one-cycle pulse: request k accepted
done_o  output  N_REQ  one-cycle pulse: result for k on y_bo
y_bo  output  W  result, valid in the done_o cycle, held until next done
err_o  output  1  one-cycle pulse with done_o when the operation aborted
busy_o  output  1  high from accept until the done cycle inclusive
cube_start_o  output  1  start to cube unit
cube_x_bo  output  W  operand to cube unit
cube_busy_i  input  1  busy from cube unit
cube_y_bi  input  W  result from cube unit

Behaviour:
- Reset (rst_i=0, async): all outputs 0, state IDLE, rr pointer 0, counters 0. Reset mid-operation abandons it; no done/err is issued.
- All outputs are registered.
- IDLE:
  - If any req_i bit is set, grant the first set bit searching from rr pointer upward with wrap.
  - Latch index g and x_bi[g] into cube_x_bo.
  - Next cycle: ack_o[g]=1, cube_start_o=1, busy_o=1. Go to START.
  - rr pointer becomes g+1 mod N_REQ.
- START:
  - Hold cube_start_o=1 and cube_x_bo.
  - cube_busy_i=1 -> cube_start_o=0, go to RUN, clear counter.
  - BUSY_WAIT cycles elapse without busy -> abort.
- RUN:
  - When cube_busy_i=0, capture cube_y_bi.
  - Next cycle: done_o[g]=1, y_bo=captured value. Go to IDLE.
  - Counter reaching TIMEOUT -> abort.
- Abort: next cycle done_o[g]=1, err_o=1, y_bo=0, cube_start_o=0. Go to IDLE.
- ack_o, done_o and err_o are single-cycle pulses, at most one bit set.
- busy_o stays high through the done cycle; it falls the cycle after.
- Minimum spacing is one IDLE cycle between done and the next ack, so back-to-back requests are not starved.
- A req dropped before its ack is never granted. A req asserted in the done cycle is considered in the following IDLE cycle.
- A req still high after its ack is treated as a new request (requesters drop req on ack).
- Simultaneous requests: strict round-robin. With all N_REQ requesting continuously, each is served once per N_REQ operations.
- x_bi changes after ack have no effect; the operand is latched at grant.
- cube_busy_i high while in IDLE is ignored.

Test Plan:
- Single request: reset, req_i=0001, x_bi[7:0]=27, cube model busy 5 cycles returning 3 -> ack_o=0001 one cycle, cube_x_bo=27, done_o=0001 with y_bo=3, err_o=0, busy_o low one cycle after done.
- Round-robin: req_i=1111 held (drop each on its ack), operands 0,1,8,64 -> grants in order 0,1,2,3; results 0,1,2,4 on matching done_o bits.
- Fairness: requester 0 re-requests immediately and requester 2 requests continuously -> grants alternate 0,2,0,2.
- Start timeout: cube model never raises busy -> after BUSY_WAIT=4 cycles, done_o[g]=1, err_o=1, y_bo=0; the next request is served normally.
- Run timeout: busy stuck high with TIMEOUT=15 -> done and err pulse 15-16 cycles after busy rises; cube_start_o=0.
- Reset mid-RUN: rst_i low for 1 cycle -> all outputs 0 immediately, no done_o pulse; a fresh req_i=0100 with x=125 then returns 5 on done_o=0100.

Source files
------------

// File: rtl/cube_arbiter.sv
// cube_arbiter: round-robin sharing of one cube-root unit between N_REQ
// requesters, with start and run watchdogs that abort a hung unit.
module cube_arbiter #(
  parameter int N_REQ     = 4,
  parameter int W         = 8,
  parameter int BUSY_WAIT = 4,
  parameter int TIMEOUT   = 1023
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [N_REQ*W-1:0] x_bi,
  output logic [N_REQ-1:0]   ack_o,
  output logic [N_REQ-1:0]   done_o,
  output logic [W-1:0]       y_bo,
  output logic               err_o,
  output logic               busy_o,
  output logic               cube_start_o,
  output logic [W-1:0]       cube_x_bo,
  input  logic               cube_busy_i,
  input  logic [W-1:0]       cube_y_bi
);

  localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CMAX = (TIMEOUT > BUSY_WAIT) ? TIMEOUT : BUSY_WAIT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] BW_LAST = CW'(BUSY_WAIT - 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);
  localparam logic [IW-1:0] LAST = IW'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] rr;
  logic [IW-1:0] g;
  logic [CW-1:0] cnt;
  logic [IW-1:0] pick;
  logic          pick_ok;
  logic [IW-1:0] rr_nxt;
  logic [IW-1:0] idx [N_REQ];

  // Walk downward so the lowest offset from rr wins.
  always_comb begin
    pick_ok = 1'b0;
    pick    = '0;
    for (int o = 0; o < N_REQ; o++) begin
      idx[o] = IW'((int'(rr) + o) % N_REQ);
    end
    for (int o = N_REQ - 1; o >= 0; o--) begin
      if (req_i[idx[o]]) begin
        pick_ok = 1'b1;
        pick    = idx[o];
      end
    end
  end

  assign rr_nxt = (pick == LAST) ? '0 : pick + 1'b1;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      rr           <= '0;
      g            <= '0;
      cnt          <= '0;
      ack_o        <= '0;
      done_o       <= '0;
      y_bo         <= '0;
      err_o        <= 1'b0;
      busy_o       <= 1'b0;
      cube_start_o <= 1'b0;
      cube_x_bo    <= '0;
    end else begin
      ack_o  <= '0;
      done_o <= '0;
      err_o  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_ok) begin
            g            <= pick;
            cube_x_bo    <= x_bi[int'(pick)*W +: W];
            ack_o        <= ONE << pick;
            cube_start_o <= 1'b1;
            busy_o       <= 1'b1;
            rr           <= rr_nxt;
            cnt          <= '0;
            state        <= START;
          end
        end
        START: begin
          if (cube_busy_i) begin
            cube_start_o <= 1'b0;
            cnt          <= '0;
            state        <= RUN;
          end else if (cnt == BW_LAST) begin
            done_o       <= ONE << g;
            err_o        <= 1'b1;
            y_bo         <= '0;
            cube_start_o <= 1'b0;
            state        <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (!cube_busy_i) begin
            y_bo   <= cube_y_bi;
            done_o <= ONE << g;
            state  <= DONE;
          end else if (cnt == TO_LAST) begin
            done_o       <= ONE << g;
            err_o        <= 1'b1;
            y_bo         <= '0;
            cube_start_o <= 1'b0;
            state        <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cube_arbiter.sv
// tb_cube_arbiter: random requesters and a behavioural cube unit,
// scored against a transaction-level round-robin reference.
module tb_cube_arbiter;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic [3:0]  req_i = '0;
  logic [31:0] x_bi = '0;
  logic [3:0]  ack_o, done_o;
  logic [7:0]  y_bo, cube_x_bo;
  logic        err_o, busy_o, cube_start_o;
  logic        cube_busy_i = 1'b0;
  logic [7:0]  cube_y_bi = '0;

  always #5 clk = ~clk;

  cube_arbiter #(
    .N_REQ(4), .W(8), .BUSY_WAIT(4), .TIMEOUT(15)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .x_bi(x_bi),
    .ack_o(ack_o), .done_o(done_o), .y_bo(y_bo), .err_o(err_o),
    .busy_o(busy_o), .cube_start_o(cube_start_o),
    .cube_x_bo(cube_x_bo), .cube_busy_i(cube_busy_i),
    .cube_y_bi(cube_y_bi)
  );

  int n_vec = 0, n_err = 0, cyc = 0, ndone = 0, idle_cnt = 0;
  int rr_m = 0, pg = 0, px = 0, pmode = 0, ack_cyc = 0, raise_cyc = 0;
  int last_y = 0, cm_wait = 0, cm_len = 0, cm_x = 0;
  int force_mode = 0, force_len = 3, force_wait = 0;
  bit pend = 0, cm_act = 0, rand_en = 0;
  bit [3:0] always_m = '0;
  int grants[$];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic int cbrt(int x);
    int r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic int rr_pick(bit [3:0] r, int p);
    for (int o = 0; o < 4; o++) begin
      if (r[(p + o) % 4]) return (p + o) % 4;
    end
    return -1;
  endfunction

  task automatic step();
    int g, ey, r;
    bit er;
    @(negedge clk);
    cyc++;
    // grant side of the reference
    if (ack_o != 0) begin
      g = rr_pick(req_i, rr_m);
      check("ack_idle", pend, 0);
      check("ack", ack_o, (g < 0) ? 0 : (1 << g));
      if (g >= 0) begin
        check("cube_x", cube_x_bo, x_bi[g*8 +: 8]);
        pend = 1; pg = g; px = x_bi[g*8 +: 8];
        rr_m = (g + 1) % 4; ack_cyc = cyc;
        grants.push_back(g);
        if (force_mode >= 0) begin
          pmode = force_mode; cm_len = force_len; cm_wait = force_wait;
        end else begin
          r = $urandom_range(0, 9);
          pmode = (r == 0) ? 1 : (r == 1) ? 2 : 0;
          cm_len = $urandom_range(1, 8);
          cm_wait = $urandom_range(0, 2);
        end
        cube_busy_i = 1'b0; cm_act = 0;
      end
    end
    if (req_i != 0 && !pend) idle_cnt++;
    else idle_cnt = 0;
    if (idle_cnt > 4) begin
      check("ack_wait", idle_cnt, 0);
      idle_cnt = 0;
    end
    check("busy", busy_o, pend);
    if (done_o != 0) begin
      er = (pmode != 0);
      ey = er ? 0 : cbrt(px);
      check("done_pend", pend, 1);
      check("done", done_o, 1 << pg);
      check("err", err_o, er);
      check("y", y_bo, ey);
      if (pmode == 1) check("bw_lat", cyc - ack_cyc, 4);
      if (pmode == 2) begin
        check("to_lat", (cyc - raise_cyc) inside {[15:16]}, 1);
        check("to_start", cube_start_o, 0);
      end
      last_y = ey; pend = 0; ndone++;
    end else begin
      check("err_idle", err_o, 0);
    end
    check("y_hold", y_bo, last_y);
    if (pend && cyc - ack_cyc > 60) begin
      check("watchdog", cyc - ack_cyc, 0);
      pend = 0;
    end
    // behavioural cube unit
    if (cube_busy_i) begin
      if (pmode == 0 && cm_len > 0) begin
        cm_len--;
        if (cm_len == 0) begin
          cube_busy_i = 1'b0;
          cube_y_bi = 8'(cbrt(cm_x));
        end
      end
    end else if (pend && cube_start_o && pmode != 1 && !cm_act) begin
      if (cm_wait > 0) cm_wait--;
      else begin
        cube_busy_i = 1'b1; cm_act = 1; cm_x = cube_x_bo;
        raise_cyc = cyc; cube_y_bi = 8'($urandom);
      end
    end
    // requesters drop on ack
    for (int k = 0; k < 4; k++) begin
      if (req_i[k] && ack_o[k]) begin
        req_i[k] = 1'b0;
      end else if (!req_i[k] && (always_m[k] ||
                 (rand_en && $urandom_range(0, 7) == 0))) begin
        req_i[k] = 1'b1;
        x_bi[k*8 +: 8] = 8'($urandom);
      end else if (!req_i[k] && rand_en) begin
        x_bi[k*8 +: 8] = 8'($urandom);
      end else if (rand_en && req_i[k] && $urandom_range(0, 63) == 0) begin
        req_i[k] = 1'b0;
      end
    end
  endtask

  task automatic apply_reset();
    req_i = '0;
    rst_i = 1'b0;
    #1;
    check("rst_out", {ack_o, done_o, y_bo, err_o, busy_o,
                      cube_start_o, cube_x_bo}, 0);
    pend = 0; rr_m = 0; last_y = 0; cm_act = 0;
    cube_busy_i = 1'b0;
    grants.delete();
    step();
    rst_i = 1'b1;
    step();
  endtask

  task automatic run_until_done(int n);
    int t0 = ndone;
    for (int i = 0; i < 300 && ndone < t0 + n; i++) step();
    check("ops_done", ndone - t0, n);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && (pend || busy_o); i++) step();
    step();
    step();
  endtask

  initial begin
    int t0;
    apply_reset();
    step();
    check("rst_busy", busy_o, 0);

    // single request
    force_mode = 0; force_len = 5; force_wait = 0;
    x_bi[7:0] = 8'd27; req_i = 4'b0001;
    run_until_done(1);
    check("single_y", y_bo, 3);
    step();
    check("single_busy_fall", busy_o, 0);

    // round-robin from pointer 0
    apply_reset();
    x_bi = {8'd64, 8'd8, 8'd1, 8'd0};
    req_i = 4'b1111;
    force_len = 2;
    run_until_done(4);
    wait_idle();
    check("rr_cnt", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++)
      check("rr_order", grants[i], i);

    // fairness: 0 re-requests, 2 continuous
    apply_reset();
    always_m = 4'b0101;
    req_i = 4'b0101;
    run_until_done(4);
    always_m = '0; req_i = '0;
    wait_idle();
    for (int i = 0; i < 4 && i < grants.size(); i++)
      check("fair_order", grants[i], (i % 2) * 2);

    // start timeout then normal service
    force_mode = 1;
    x_bi[7:0] = 8'd8; req_i = 4'b0001;
    run_until_done(1);
    check("bw_err", last_y, 0);
    force_mode = 0;
    x_bi[15:8] = 8'd27; req_i = 4'b0010;
    run_until_done(1);
    check("bw_after", y_bo, 3);

    // run timeout with busy stuck
    force_mode = 2; force_wait = 0;
    x_bi[23:16] = 8'd1; req_i = 4'b0100;
    run_until_done(1);
    wait_idle();

    // reset during RUN
    force_mode = 0; force_len = 10;
    x_bi[7:0] = 8'd100; req_i = 4'b0001;
    for (int i = 0; i < 40 && !(cube_busy_i && busy_o && !cube_start_o); i++)
      step();
    check("in_run", cube_busy_i && busy_o && !cube_start_o, 1);
    t0 = ndone;
    apply_reset();
    for (int i = 0; i < 6; i++) step();
    check("no_done_after_rst", ndone - t0, 0);
    force_len = 4;
    x_bi[23:16] = 8'd125; req_i = 4'b0100;
    run_until_done(1);
    check("rst_fresh_y", y_bo, 5);
    check("rst_fresh_g", grants.size() > 0 ? grants[0] : -1, 2);

    // randomized traffic
    force_mode = -1;
    rand_en = 1;
    t0 = ndone;
    for (int i = 0; i < 3000; i++) step();
    rand_en = 0;
    req_i = '0;
    wait_idle();
    check("rand_progress", (ndone - t0) > 50, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
